// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the 4-bit CPU fetch/decode path: opcodes, ALU
// operand selects and instruction field positions.
package instr_fetch_pkg;

    // Instruction fields: op in the top nibble, immediate in the bottom nibble
    localparam int OP_W    = 4;
    localparam int IMM_W   = 4;
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    // Opcodes understood by the decoder; OP_HLT stops the sequencer
    localparam logic [OP_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD_A_IM = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD_B_IM = 4'h2;
    localparam logic [OP_W-1:0] OP_HLT      = 4'hF;

    // Operand selects used by the execute side
    localparam logic [1:0] SEL_A  = 2'd0;
    localparam logic [1:0] SEL_B  = 2'd1;
    localparam logic [1:0] SEL_IM = 2'd2;

    function automatic logic is_halt(input logic [OP_W-1:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/instr_fetch_prog_store.sv
// Program store: register array, cleared by reset, written synchronously,
// read combinationally so a write becomes visible on the following cycle.
module instr_fetch_prog_store #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];

    // Next contents: unchanged except the addressed entry on a write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage array; reset clears every entry to NOP
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: program counter, program store and a
// registered valid/ready output stage feeding the instruction decoder.
// Optional breakpoint support is enabled with INSTR_FETCH_BREAKPOINT_EN.
//
// Handshake: an instruction moves when out_valid & out_ready are both high
// at a rising edge. out_valid is a pure register output and never depends
// on out_ready in the same cycle; while out_valid is high and out_ready is
// low, op_out/im_out/pc_out stay frozen.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               run,
    input  logic               pc_clear,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    op_out,
    output logic [IMM_W-1:0]   im_out,
    output logic [ADDR_W-1:0]  pc_out,
`ifdef INSTR_FETCH_BREAKPOINT_EN
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    output logic               bp_hit,
`endif
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
`ifdef INSTR_FETCH_BREAKPOINT_EN
    logic               bp_hit_q, bp_hit_d;
`endif

    logic               store_we;
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic [ADDR_W-1:0]  seq_pc;
    logic [ADDR_W-1:0]  start_pc;

    // Sequential successor wraps naturally at 2**ADDR_W
    assign seq_pc   = jump_en ? jump_addr : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign start_pc = pc_clear ? '0 : pc_q;

    instr_fetch_prog_store #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_store (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (store_we),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

    // Next-state, next-PC and output-register load decisions
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        store_we = 1'b0;
        rd_addr  = pc_q;
`ifdef INSTR_FETCH_BREAKPOINT_EN
        bp_hit_d = bp_hit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                store_we = prog_we;
                pc_d     = start_pc;
                rd_addr  = start_pc;
                if (run) begin
                    instr_d = rd_data;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_addr = seq_pc;
                if (out_ready) begin
                    if (is_halt(instr_q[INSTR_W-1 -: OP_W])) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = seq_pc;
`ifdef INSTR_FETCH_BREAKPOINT_EN
                        if (bp_en && (seq_pc == bp_addr)) begin
                            state_d  = ST_HALT;
                            bp_hit_d = 1'b1;
                        end else begin
                            instr_d = rd_data;
                        end
`else
                        instr_d = rd_data;
`endif
                    end
                end
            end
            ST_HALT: begin
                store_we = prog_we;
                if (pc_clear) begin
                    pc_d = '0;
                end
                if (!run) begin
                    state_d = ST_IDLE;
`ifdef INSTR_FETCH_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and presented-instruction registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
`ifdef INSTR_FETCH_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
`ifdef INSTR_FETCH_BREAKPOINT_EN
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign op_out    = instr_q[INSTR_W-1 -: OP_W];
    assign im_out    = instr_q[IMM_W-1:0];
    assign pc_out    = pc_q;
`ifdef INSTR_FETCH_BREAKPOINT_EN
    assign bp_hit    = bp_hit_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       run, pc_clear, prog_we, jump_en, out_ready;
    logic [3:0] prog_addr, jump_addr;
    logic [7:0] prog_data;
    logic       out_valid, halted;
    logic [3:0] op_out, im_out, pc_out;
`ifdef INSTR_FETCH_BREAKPOINT_EN
    logic       bp_en;
    logic [3:0] bp_addr;
    logic       bp_hit;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .run       (run),
        .pc_clear  (pc_clear),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_out    (op_out),
        .im_out    (im_out),
        .pc_out    (pc_out),
`ifdef INSTR_FETCH_BREAKPOINT_EN
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .bp_hit    (bp_hit),
`endif
        .halted    (halted)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a running flag, a halted flag, the PC and the
    // instruction captured when it was fetched.
    logic [7:0] m_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_instr;
    logic       m_running, m_halted, m_bp;

    always @(posedge clk or negedge n_reset) begin : model
        logic [3:0] np;
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
            m_pc <= 4'd0; m_instr <= 8'h00;
            m_running <= 1'b0; m_halted <= 1'b0; m_bp <= 1'b0;
        end else if (m_running) begin
            if (out_ready) begin
                if (m_instr[7:4] == 4'hF) begin
                    m_running <= 1'b0;
                    m_halted  <= 1'b1;
                end else begin
                    np = jump_en ? jump_addr : m_pc + 4'd1;
                    m_pc <= np;
`ifdef INSTR_FETCH_BREAKPOINT_EN
                    if (bp_en && np == bp_addr) begin
                        m_running <= 1'b0; m_halted <= 1'b1; m_bp <= 1'b1;
                    end else begin
                        m_instr <= m_mem[np];
                    end
`else
                    m_instr <= m_mem[np];
`endif
                end
            end
        end else begin
            np = pc_clear ? 4'd0 : m_pc;
            m_pc <= np;
            if (prog_we) m_mem[prog_addr] <= prog_data;
            if (!m_halted && run) begin
                m_instr   <= m_mem[np];
                m_running <= 1'b1;
            end
            if (m_halted && !run) begin
                m_halted <= 1'b0;
                m_bp     <= 1'b0;
            end
        end
    end

    // Compare DUT outputs with the model once per cycle, away from the edge
    always @(negedge clk) begin
        if (chk_en && n_reset) begin
            check("out_valid", {7'd0, out_valid}, {7'd0, m_running});
            check("halted", {7'd0, halted}, {7'd0, m_halted});
            check("pc_out", {4'd0, pc_out}, {4'd0, m_pc});
            if (m_running) begin
                check("op_out", {4'd0, op_out}, {4'd0, m_instr[7:4]});
                check("im_out", {4'd0, im_out}, {4'd0, m_instr[3:0]});
            end
`ifdef INSTR_FETCH_BREAKPOINT_EN
            check("bp_hit", {7'd0, bp_hit}, {7'd0, m_bp});
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        cyc(1);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        cyc(2);
        n_reset = 1'b1;
    endtask

    task automatic expect_insn(input string name, input logic [3:0] pc,
                               input logic [3:0] op, input logic [3:0] imm);
        check({name, "_valid"}, {7'd0, out_valid}, 8'd1);
        check({name, "_pc"}, {4'd0, pc_out}, {4'd0, pc});
        check({name, "_op"}, {4'd0, op_out}, {4'd0, op});
        check({name, "_imm"}, {4'd0, im_out}, {4'd0, imm});
    endtask

    function automatic logic [7:0] rand_instr();
        logic [3:0] op;
        op = (($urandom_range(0, 5)) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        return {op, 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        n_reset = 1'b0; run = 1'b0; pc_clear = 1'b0; prog_we = 1'b0;
        prog_addr = 4'd0; prog_data = 8'd0; jump_en = 1'b0; jump_addr = 4'd0;
        out_ready = 1'b0;
`ifdef INSTR_FETCH_BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 4'd0;
`endif
        #1;
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_halted", {7'd0, halted}, 8'd0);
        check("rst_pc", {4'd0, pc_out}, 8'd0);
        check("rst_op", {4'd0, op_out}, 8'd0);
        check("rst_imm", {4'd0, im_out}, 8'd0);
        cyc(2);
        n_reset = 1'b1;
        chk_en = 1'b1;

        // Straight-line program ending in HLT
        load(4'd0, 8'h13); load(4'd1, 8'h25); load(4'd2, 8'hF0);
        run = 1'b1; out_ready = 1'b1;
        cyc(1); run = 1'b0;
        expect_insn("t1_i0", 4'd0, 4'h1, 4'h3);
        cyc(1); expect_insn("t1_i1", 4'd1, 4'h2, 4'h5);
        cyc(1); expect_insn("t1_i2", 4'd2, 4'hF, 4'h0);
        cyc(1);
        check("t1_halt_valid", {7'd0, out_valid}, 8'd0);
        check("t1_halted", {7'd0, halted}, 8'd1);
        check("t1_halt_pc", {4'd0, pc_out}, 8'd2);

        // Stall with jump_en toggling, then a taken jump at pc 4
        load(4'd2, 8'h00); load(4'd3, 8'h11); load(4'd4, 8'h22);
        load(4'd5, 8'h13); load(4'd9, 8'h27); load(4'd10, 8'hF0);
        run = 1'b1;
        cyc(1); run = 1'b0;
        expect_insn("t2_start", 4'd2, 4'h0, 4'h0);
        out_ready = 1'b0; jump_addr = 4'd9;
        for (int i = 0; i < 4; i++) begin
            jump_en = ~jump_en; run = jump_en;
            cyc(1);
            expect_insn("t2_stall", 4'd2, 4'h0, 4'h0);
        end
        out_ready = 1'b1; jump_en = 1'b0; run = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd9; prog_data = 8'hEE;
        cyc(1); prog_we = 1'b0;
        expect_insn("t2_seq", 4'd3, 4'h1, 4'h1);
        cyc(1); expect_insn("t2_pc4", 4'd4, 4'h2, 4'h2);
        jump_en = 1'b1;
        cyc(1); jump_en = 1'b0;
        expect_insn("t2_jump", 4'd9, 4'h2, 4'h7);
        cyc(1); expect_insn("t2_hlt", 4'd10, 4'hF, 4'h0);
        cyc(1);
        check("t2_halted", {7'd0, halted}, 8'd1);

        // Write while halted, then return to IDLE, clear PC and restart
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h3A;
        cyc(1); prog_we = 1'b0;
        pc_clear = 1'b1; cyc(1); pc_clear = 1'b0;
        run = 1'b1; cyc(1); run = 1'b0;
        expect_insn("t3_restart", 4'd0, 4'h3, 4'hA);

        // After reset the store is all NOPs; jump to 15 and wrap to 0
        do_reset();
        run = 1'b1; cyc(1); run = 1'b0;
        expect_insn("t4_start", 4'd0, 4'h0, 4'h0);
        jump_en = 1'b1; jump_addr = 4'd15;
        cyc(1); jump_en = 1'b0;
        expect_insn("t4_pc15", 4'd15, 4'h0, 4'h0);
        cyc(1); expect_insn("t4_wrap", 4'd0, 4'h0, 4'h0);
        cyc(6); expect_insn("t4_pc6", 4'd6, 4'h0, 4'h0);
        #2 n_reset = 1'b0;
        #1;
        check("t4_rst_valid", {7'd0, out_valid}, 8'd0);
        check("t4_rst_pc", {4'd0, pc_out}, 8'd0);
        check("t4_rst_halted", {7'd0, halted}, 8'd0);
        cyc(1); n_reset = 1'b1;

`ifdef INSTR_FETCH_BREAKPOINT_EN
        // Breakpoint at 3 stops before presenting it, then resumes there
        load(4'd0, 8'h11); load(4'd1, 8'h12); load(4'd2, 8'h13); load(4'd3, 8'h24);
        bp_en = 1'b1; bp_addr = 4'd3;
        run = 1'b1; cyc(1); run = 1'b0;
        expect_insn("bp_i0", 4'd0, 4'h1, 4'h1);
        cyc(2); expect_insn("bp_i2", 4'd2, 4'h1, 4'h3);
        cyc(1);
        check("bp_hit_set", {7'd0, bp_hit}, 8'd1);
        check("bp_halted", {7'd0, halted}, 8'd1);
        check("bp_pc", {4'd0, pc_out}, 8'd3);
        check("bp_valid", {7'd0, out_valid}, 8'd0);
        cyc(1);
        check("bp_hit_clr", {7'd0, bp_hit}, 8'd0);
        bp_en = 1'b0; run = 1'b1; cyc(1); run = 1'b0;
        expect_insn("bp_resume", 4'd3, 4'h2, 4'h4);
        do_reset();
`endif

        // Randomized traffic checked by the model
        for (int i = 0; i < 16; i++) load(4'(i), rand_instr());
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            jump_en   = ($urandom_range(0, 5) == 0);
            jump_addr = 4'($urandom_range(0, 15));
            run       = ($urandom_range(0, 2) != 0);
            pc_clear  = !run && ($urandom_range(0, 3) == 0);
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = 4'($urandom_range(0, 15));
            prog_data = rand_instr();
`ifdef INSTR_FETCH_BREAKPOINT_EN
            bp_en   = ($urandom_range(0, 3) == 0);
            bp_addr = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 n_reset = 1'b0;
                #1 check("rand_rst_valid", {7'd0, out_valid}, 8'd0);
                cyc(1); n_reset = 1'b1;
            end else begin
                cyc(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
